spi_slave_responder: RTL and testbench
======================================

Name: spi_slave_responder

Overview:
- SPI mode-0 slave that sits at the far end of the proyecto2 SPI master link, in the remote device addressed by the master's Address byte.
- Oversamples SPI_clk, SPI_CS and SPI_MOSI with Mclk and decodes frames of the form address byte, command byte, then NBYTES payload bytes.
- A write frame delivers a 120-bit payload to local logic.
- A read frame shifts out a locally supplied 120-bit word on SPI_MISO.

Parameters:
- NBYTES, 15, payload bytes per frame; data width is 8*NBYTES.
- SYNC_STAGES, 2, flip-flop synchroniser depth on SPI_clk, SPI_CS and SPI_MOSI (minimum 2).
- CMD_WR, 8'h01, write command code.
- CMD_RD, 8'h02, read command code.

Ports:
- Mclk  in  1  system clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- My_Address  in  8  this device's address, compared against frame byte 0.
- SPI_clk  in  1  SPI serial clock, idle low; its frequency must be ≤ Mclk/8.
- SPI_CS  in  1  chip select, active low.
- SPI_MOSI  in  1  master-to-slave data, MSB first.
- SPI_MISO  out  1  slave-to-master data, MSB first.
- SPI_MISO_OE  out  1  output enable for the MISO pad driver.
- Tx_Data  in  8*NBYTES  read-back word, sampled when a read command completes.
- Rx_Data  out  8*NBYTES  last valid write payload.
- Rx_Valid  out  1  one-cycle pulse when Rx_Data updates.
- Frame_Error  out  1  one-cycle pulse on a malformed addressed frame.
- Busy  out  1  high while an addressed frame is in progress.

Behaviour:
- Reset values: SPI_MISO=0, SPI_MISO_OE=0, Rx_Data=0, Rx_Valid=0, Frame_Error=0, Busy=0, state=WAIT_CS_HIGH, counters=0.
- Synchronised inputs feed edge detectors; all decisions use the detected SCLK rise/fall and CS rise/fall single-cycle strobes.
- SCLK rise: shift MOSI into an 8-bit register and increment a 3-bit bit counter; the count wraps 7→0 and marks byte complete.
- States:
  - WAIT_CS_HIGH: entered after reset; move to IDLE once synced CS=1. This prevents joining a frame mid-stream.
  - IDLE: CS fall → ADDR; clear bit and byte counters.
  - ADDR: on byte complete, byte==My_Address → CMD and Busy=1; otherwise → IGNORE.
  - CMD:
    - byte==CMD_WR → WDATA.
    - byte==CMD_RD → RDATA: latch Tx_Data into the tx shift register and set SPI_MISO_OE=1.
    - any other byte → IGNORE, flag bad_cmd.
  - WDATA: each completed byte is shifted into the payload register; the first byte lands in bits [8*NBYTES-1 -: 8]. Byte counter saturates at NBYTES+1.
  - RDATA:
    - On each SCLK fall, SPI_MISO takes the next tx bit, MSB of Tx_Data first.
    - The first fall after the command byte presents bit 8*NBYTES-1.
    - After 8*NBYTES bits, SPI_MISO is held at 0.
    - MOSI is ignored.
  - IGNORE: MISO_OE=0; wait for CS rise.
- CS rise in any active state → IDLE; SPI_MISO_OE=0 and Busy=0 on the same cycle.
- Frame check on CS rise:
  - WDATA with exactly NBYTES bytes and bit counter 0: Rx_Data updates, then Rx_Valid pulses 1 cycle after the CS rise strobe.
  - WDATA with too few or too many bytes, or a partial byte: Frame_Error pulse, Rx_Data unchanged.
  - RDATA with bit counter ≠ 0: Frame_Error pulse.
  - IGNORE with bad_cmd: Frame_Error pulse.
  - Address mismatch: silent, no pulses.
  - CS rise during ADDR or CMD (before the command is decoded): silent, no pulses.
- Rx_Valid and Frame_Error are never high in the same cycle.
- Reset asserted mid-frame aborts the frame:
  - all outputs return to reset values;
  - state goes to WAIT_CS_HIGH, and the remaining bits of the frame are not decoded.
- SCLK edges while CS=1 are ignored.

Test Plan:
- Write frame: My_Address=8'h5A, bytes 5A 01 3f a0 bc fa df e3 41 00 21 bb c9 fa e2 5a 1f, SCLK=Mclk/16, then CS rise → Rx_Data=120'h3fa0bcfadfe3410021bbc9fae25a1f; one Rx_Valid pulse; Frame_Error stays 0.
- Read frame: Tx_Data=120'h2f900921f4a254e4ff0012dcbbaa45; frame 5A 02 followed by 15 dummy bytes → MISO bytes sampled on SCLK rises read 2f 90 09 … 45; SPI_MISO_OE=1 only between command complete and CS rise.
- Address mismatch: frame 5B 01 plus 15 bytes → Rx_Data unchanged, no pulses, SPI_MISO_OE=0 throughout, Busy=0.
- Short and bad frames:
  - 5A 01 plus 14 bytes → Frame_Error pulse, Rx_Data unchanged.
  - 5A 07 plus 15 bytes → Frame_Error pulse.
  - Write frame with CS rising after 3 bits of the last byte → Frame_Error pulse.
- Reset mid-frame: assert Reset for 2 cycles during data byte 6 of a write frame → Busy=0 and no Rx_Valid. A following clean write frame of 15 bytes 8'h11 gives Rx_Data of all 8'h11 and one Rx_Valid pulse.
- Back-to-back frames: write frame, CS high for 4 Mclk cycles, then read frame → Rx_Valid pulse once, then correct read-back data with no lost bits.

Source files
------------

// File: rtl/spi_slave_responder.sv
// ============================================================================
//  Module   : spi_slave_responder
//  Purpose  : SPI mode-0 slave, oversampled by Mclk; decodes address/command/
//             payload frames into a write payload or a read-back shift-out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave_responder #(
    parameter int         NBYTES      = 15,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] CMD_WR      = 8'h01,
    parameter logic [7:0] CMD_RD      = 8'h02
) (
    input  logic                  Mclk,
    input  logic                  Reset,
    input  logic [7:0]            My_Address,
    input  logic                  SPI_clk,
    input  logic                  SPI_CS,
    input  logic                  SPI_MOSI,
    output logic                  SPI_MISO,
    output logic                  SPI_MISO_OE,
    input  logic [8*NBYTES-1:0]   Tx_Data,
    output logic [8*NBYTES-1:0]   Rx_Data,
    output logic                  Rx_Valid,
    output logic                  Frame_Error,
    output logic                  Busy
);

    localparam int             c_W      = 8 * NBYTES;
    localparam int             c_BCW    = $clog2(NBYTES + 2);
    localparam logic [c_BCW-1:0] c_NB     = c_BCW'(NBYTES);
    localparam logic [c_BCW-1:0] c_NB_SAT = c_BCW'(NBYTES + 1);
    localparam logic [c_BCW-1:0] c_ONE    = c_BCW'(1);

    typedef enum logic [2:0] {
        S_WAIT_CS_HIGH = 3'd0,
        S_IDLE         = 3'd1,
        S_ADDR         = 3'd2,
        S_CMD          = 3'd3,
        S_WDATA        = 3'd4,
        S_RDATA        = 3'd5,
        S_IGNORE       = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    logic w_sclk;
    logic w_cs;
    logic w_mosi;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;

    state_t             r_state;
    logic [6:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic [c_BCW-1:0]   r_byte_cnt;
    logic [c_W-1:0]     r_payload;
    logic [c_W-1:0]     r_tx_shift;
    logic [c_W-1:0]     r_rx_data;
    logic               r_bad_cmd;
    logic               r_miso;
    logic               r_miso_oe;
    logic               r_rx_valid;
    logic               r_frame_err;
    logic               r_busy;

    logic [7:0]         w_byte;
    logic               w_byte_done;
    logic               w_in_frame;

    // CS synchroniser resets low so a device reset while CS is held low
    // cannot be mistaken for an idle bus.
    always_ff @(posedge Mclk) begin
        if (Reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SPI_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], SPI_CS};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
            r_sclk_prev <= w_sclk;
            r_cs_prev   <= w_cs;
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs        = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_prev & ~w_cs;
    assign w_sclk_fall = ~w_sclk & r_sclk_prev & ~w_cs;
    assign w_cs_rise   = w_cs & ~r_cs_prev;
    assign w_cs_fall   = ~w_cs & r_cs_prev;

    assign w_byte      = {r_shift, w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);
    assign w_in_frame  = (r_state != S_WAIT_CS_HIGH) && (r_state != S_IDLE);

    always_ff @(posedge Mclk) begin
        if (Reset) begin
            r_state     <= S_WAIT_CS_HIGH;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_payload   <= '0;
            r_tx_shift  <= '0;
            r_rx_data   <= '0;
            r_bad_cmd   <= 1'b0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;

            if (w_sclk_rise && w_in_frame) begin
                r_shift   <= w_byte[6:0];
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            case (r_state)
                S_WAIT_CS_HIGH: begin
                    if (w_cs) begin
                        r_state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_state    <= S_ADDR;
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= '0;
                        r_bad_cmd  <= 1'b0;
                    end
                end

                default: begin
                    if (w_cs_rise) begin
                        r_state   <= S_IDLE;
                        r_miso_oe <= 1'b0;
                        r_busy    <= 1'b0;
                        r_miso    <= 1'b0;
                        case (r_state)
                            S_WDATA: begin
                                if ((r_byte_cnt == c_NB) && (r_bit_cnt == 3'd0)) begin
                                    r_rx_data  <= r_payload;
                                    r_rx_valid <= 1'b1;
                                end else begin
                                    r_frame_err <= 1'b1;
                                end
                            end
                            S_RDATA: begin
                                if (r_bit_cnt != 3'd0) begin
                                    r_frame_err <= 1'b1;
                                end
                            end
                            S_IGNORE: begin
                                if (r_bad_cmd) begin
                                    r_frame_err <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        case (r_state)
                            S_ADDR: begin
                                if (w_byte_done) begin
                                    if (w_byte == My_Address) begin
                                        r_state <= S_CMD;
                                        r_busy  <= 1'b1;
                                    end else begin
                                        r_state <= S_IGNORE;
                                    end
                                end
                            end
                            S_CMD: begin
                                if (w_byte_done) begin
                                    if (w_byte == CMD_WR) begin
                                        r_state <= S_WDATA;
                                    end else if (w_byte == CMD_RD) begin
                                        r_state    <= S_RDATA;
                                        r_tx_shift <= Tx_Data;
                                        r_miso_oe  <= 1'b1;
                                    end else begin
                                        r_state   <= S_IGNORE;
                                        r_bad_cmd <= 1'b1;
                                    end
                                end
                            end
                            S_WDATA: begin
                                if (w_byte_done) begin
                                    r_payload <= {r_payload[c_W-9:0], w_byte};
                                    if (r_byte_cnt != c_NB_SAT) begin
                                        r_byte_cnt <= r_byte_cnt + c_ONE;
                                    end
                                end
                            end
                            S_RDATA: begin
                                // Zeros shift in behind the word, so MISO idles
                                // low once all payload bits have gone out.
                                if (w_sclk_fall) begin
                                    r_miso     <= r_tx_shift[c_W-1];
                                    r_tx_shift <= {r_tx_shift[c_W-2:0], 1'b0};
                                end
                            end
                            S_IGNORE: begin
                                r_miso_oe <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign SPI_MISO    = r_miso;
    assign SPI_MISO_OE = r_miso_oe;
    assign Rx_Data     = r_rx_data;
    assign Rx_Valid    = r_rx_valid;
    assign Frame_Error = r_frame_err;
    assign Busy        = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_responder.sv
// ============================================================================
//  Module   : tb_spi_slave_responder
//  Purpose  : Scoreboard bench: SPI master driver, frame-level reference model
//             and a pulse monitor for spi_slave_responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave_responder;

    localparam int         NB     = 15;
    localparam int         W      = 8 * NB;
    localparam logic [7:0] C_WR   = 8'h01;
    localparam logic [7:0] C_RD   = 8'h02;

    logic           Mclk = 1'b0;
    logic           Reset;
    logic [7:0]     My_Address;
    logic           SPI_clk;
    logic           SPI_CS;
    logic           SPI_MOSI;
    logic           SPI_MISO;
    logic           SPI_MISO_OE;
    logic [W-1:0]   Tx_Data;
    logic [W-1:0]   Rx_Data;
    logic           Rx_Valid;
    logic           Frame_Error;
    logic           Busy;

    spi_slave_responder dut (
        .Mclk        (Mclk),
        .Reset       (Reset),
        .My_Address  (My_Address),
        .SPI_clk     (SPI_clk),
        .SPI_CS      (SPI_CS),
        .SPI_MOSI    (SPI_MOSI),
        .SPI_MISO    (SPI_MISO),
        .SPI_MISO_OE (SPI_MISO_OE),
        .Tx_Data     (Tx_Data),
        .Rx_Data     (Rx_Data),
        .Rx_Valid    (Rx_Valid),
        .Frame_Error (Frame_Error),
        .Busy        (Busy)
    );

    always #5 Mclk = ~Mclk;

    typedef struct packed {
        logic         is_err;
        logic [W-1:0] data;
    } ev_t;

    int           n_checks = 0;
    int           n_errors = 0;
    ev_t          exp_q[$];
    logic [W-1:0] exp_rx;
    logic [7:0]   fr[$];

    task automatic tick(input int n);
        repeat (n) @(negedge Mclk);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Frame-level reference: outcome depends only on complete bytes and
    // whether the frame ended with a partial byte.
    task automatic predict(input int partial);
        ev_t          ev;
        logic [W-1:0] d;
        int           n;
        n = fr.size();
        if (n >= 2 && fr[0] == My_Address) begin
            if (fr[1] == C_WR) begin
                if (n - 2 == NB && partial == 0) begin
                    d = '0;
                    for (int k = 0; k < NB; k++) d[W-1-8*k -: 8] = fr[2+k];
                    ev.is_err = 1'b0;
                    ev.data   = d;
                    exp_q.push_back(ev);
                    exp_rx = d;
                end else begin
                    ev.is_err = 1'b1;
                    ev.data   = '0;
                    exp_q.push_back(ev);
                end
            end else if (fr[1] == C_RD) begin
                if (partial != 0) begin
                    ev.is_err = 1'b1;
                    ev.data   = '0;
                    exp_q.push_back(ev);
                end
            end else begin
                ev.is_err = 1'b1;
                ev.data   = '0;
                exp_q.push_back(ev);
            end
        end
    endtask

    // Monitor: every Rx_Valid / Frame_Error pulse consumes one expected event.
    always @(negedge Mclk) begin
        ev_t ev;
        if (Rx_Valid && Frame_Error) begin
            n_checks++;
            n_errors++;
            $display("FAIL pulse_overlap: got valid=1 err=1, required at most one");
        end else if (Rx_Valid || Frame_Error) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b, required no pulse",
                         Rx_Valid, Frame_Error);
            end else begin
                ev = exp_q.pop_front();
                if (ev.is_err !== Frame_Error) begin
                    n_errors++;
                    $display("FAIL pulse_kind: got err=%0b, required err=%0b", Frame_Error, ev.is_err);
                end else if (!ev.is_err && Rx_Data !== ev.data) begin
                    n_errors++;
                    $display("FAIL rx_data_at_valid: got %h, required %h", Rx_Data, ev.data);
                end
            end
        end
    end

    task automatic send_frame(input int h, input int partial, input int rst_byte, input int gap);
        logic [7:0] cur;
        logic [7:0] mb;
        logic [7:0] exp_b;
        int         nbits;
        int         total;
        int         k;
        bit         match;
        bit         is_wr;
        bit         is_rd;
        bit         aborted;
        match   = (fr.size() >= 1) && (fr[0] == My_Address);
        is_wr   = match && (fr.size() >= 2) && (fr[1] == C_WR);
        is_rd   = match && (fr.size() >= 2) && (fr[1] == C_RD);
        aborted = 1'b0;
        total   = fr.size() + ((partial > 0) ? 1 : 0);
        if (rst_byte < 0) predict(partial);

        SPI_CS = 1'b0;
        tick(h);
        for (int b = 0; b < total; b++) begin
            cur   = (b < fr.size()) ? fr[b] : 8'hC3;
            nbits = (b < fr.size()) ? 8 : partial;
            mb    = '0;
            for (int i = 0; i < nbits; i++) begin
                SPI_MOSI = cur[7-i];
                if (b == rst_byte && i == 3) begin
                    Reset = 1'b1;
                    tick(2);
                    Reset = 1'b0;
                    aborted = 1'b1;
                    exp_rx  = '0;
                    check("reset_rx_data", Rx_Data, '0);
                end
                tick(h);
                mb = {mb[6:0], SPI_MISO};
                if (i == 0) begin
                    check("miso_oe_in_frame", W'(SPI_MISO_OE), W'(!aborted && is_rd && b >= 2));
                    if (!match || is_wr || is_rd || aborted)
                        check("busy_in_frame", W'(Busy), W'(!aborted && match && b >= 1));
                end
                SPI_clk = 1'b1;
                tick(h);
                SPI_clk = 1'b0;
            end
            if (is_rd && !aborted && b >= 2 && nbits == 8) begin
                k     = b - 2;
                exp_b = (k < NB) ? Tx_Data[W-1-8*k -: 8] : 8'h00;
                check("miso_byte", W'(mb), W'(exp_b));
            end
        end
        tick(h);
        SPI_CS = 1'b1;
        tick(gap);
        check("busy_after_cs", W'(Busy), '0);
        check("oe_after_cs", W'(SPI_MISO_OE), '0);
        check("rx_data_after_cs", Rx_Data, exp_rx);
    endtask

    task automatic fill_payload(input logic [7:0] a, input logic [7:0] c, input int n);
        fr.delete();
        fr.push_back(a);
        fr.push_back(c);
        for (int i = 0; i < n; i++) fr.push_back(8'($urandom));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int r;
        int p;
        int nd;
        logic [7:0] a;
        logic [7:0] c;

        Reset      = 1'b1;
        SPI_clk    = 1'b0;
        SPI_CS     = 1'b1;
        SPI_MOSI   = 1'b0;
        My_Address = 8'h5A;
        Tx_Data    = '0;
        exp_rx     = '0;
        tick(4);
        Reset = 1'b0;
        check("reset_miso", W'(SPI_MISO), '0);
        check("reset_oe", W'(SPI_MISO_OE), '0);
        check("reset_rx_data", Rx_Data, '0);
        check("reset_rx_valid", W'(Rx_Valid), '0);
        check("reset_frame_error", W'(Frame_Error), '0);
        check("reset_busy", W'(Busy), '0);
        tick(6);

        // Directed write frame at SCLK = Mclk/16
        fr = '{8'h5A, 8'h01, 8'h3f, 8'ha0, 8'hbc, 8'hfa, 8'hdf, 8'he3, 8'h41,
               8'h00, 8'h21, 8'hbb, 8'hc9, 8'hfa, 8'he2, 8'h5a, 8'h1f};
        send_frame(8, 0, -1, 8);
        check("write_vector", Rx_Data, 120'h3fa0bcfadfe3410021bbc9fae25a1f);

        // Directed read frame
        Tx_Data = 120'h2f900921f4a254e4ff0012dcbbaa45;
        fill_payload(8'h5A, C_RD, NB);
        send_frame(8, 0, -1, 8);

        // Address mismatch
        fill_payload(8'h5B, C_WR, NB);
        send_frame(6, 0, -1, 8);

        // Short write, bad command, partial last byte
        fill_payload(8'h5A, C_WR, NB - 1);
        send_frame(5, 0, -1, 8);
        fill_payload(8'h5A, 8'h07, NB);
        send_frame(5, 0, -1, 8);
        fill_payload(8'h5A, C_WR, NB - 1);
        send_frame(5, 3, -1, 8);

        // Reset during data byte 6, then a clean frame of 8'h11
        fill_payload(8'h5A, C_WR, NB);
        send_frame(5, 0, 7, 8);
        fr.delete();
        fr.push_back(8'h5A);
        fr.push_back(C_WR);
        for (int i = 0; i < NB; i++) fr.push_back(8'h11);
        send_frame(5, 0, -1, 8);
        check("post_reset_write", Rx_Data, {NB{8'h11}});

        // Back-to-back write then read with a 4-cycle CS-high gap
        fill_payload(8'h5A, C_WR, NB);
        send_frame(4, 0, -1, 4);
        Tx_Data = {$urandom, $urandom, $urandom, $urandom};
        fill_payload(8'h5A, C_RD, NB);
        send_frame(4, 0, -1, 8);

        // Randomised frames
        for (int t = 0; t < 20; t++) begin
            My_Address = 8'($urandom);
            Tx_Data    = {$urandom, $urandom, $urandom, $urandom};
            a  = ($urandom_range(0, 4) == 0) ? (My_Address ^ (8'h01 << $urandom_range(0, 7))) : My_Address;
            r  = $urandom_range(0, 6);
            c  = (r < 3) ? C_WR : (r < 6) ? C_RD : 8'(8'h03 + $urandom_range(0, 249));
            r  = $urandom_range(0, 9);
            nd = (r == 0) ? NB - 1 : (r == 1) ? NB + 1 : NB;
            fill_payload(a, c, nd);
            if (r == 2) begin
                fr.delete();
                fr.push_back(a);
            end
            p = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 7) : 0;
            send_frame($urandom_range(4, 7), p, -1, $urandom_range(4, 10));
        end

        tick(10);
        check("scoreboard_drained", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
